// File: rtl/imem_program_loader_if.sv
// Byte-stream handshake between a program source and the instruction-memory
// loader. The source drives one program byte per transfer, together with a
// flag on the final byte. The loader answers with in_ready.
//   in_valid : source -> loader, in_byte/in_last are valid
//   in_ready : loader -> source, loader accepts a byte this cycle
//   in_byte  : source -> loader, program byte (little-endian within a word)
//   in_last  : source -> loader, marks the final byte of the program
// Modports: master = byte source, slave = loader.
interface imem_program_loader_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_byte;
    logic       in_last;

    modport master (output in_valid, output in_byte, output in_last, input in_ready);
    modport slave  (input in_valid, input in_byte, input in_last, output in_ready);
endinterface

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader.
// Assembles a little-endian byte stream into 32-bit words, writes each word
// to instruction memory starting at word address 0, then appends an all-zero
// halt word. The core is held (core_run=0) until a complete, well-formed
// program has been written. A partial final word, or a program that leaves
// no slot for the halt word, aborts the load with a sticky error.
// Ports:
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   start       : single-cycle pulse, begins a new load at address 0
//   in_if       : byte-stream handshake (slave side)
//   imem_we     : one-cycle write strobe per word
//   imem_addr   : word address of the write
//   imem_wdata  : word to write
//   core_run    : 1 = core may execute
//   busy        : load in progress
//   done        : last load completed successfully
//   error       : last load aborted, sticky until next start
//   word_count  : program words written by the last load (halt excluded)
// All outputs come straight from registers.
module imem_program_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    imem_program_loader_if.slave  in_if,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  core_run,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH-1:0] word_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RECV    = 3'd1,
        S_WRITE   = 3'd2,
        S_HALT_WR = 3'd3,
        S_DONE    = 3'd4,
        S_ERROR   = 3'd5
    } state_t;

    state_t                state_q;
    logic [31:0]           word_q;
    logic [1:0]            byte_idx_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic                  last_q;
    logic                  in_ready_q;
    logic                  imem_we_q;
    logic [ADDR_WIDTH-1:0] imem_addr_q;
    logic [31:0]           imem_wdata_q;
    logic                  core_run_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  error_q;
    logic [ADDR_WIDTH-1:0] word_count_q;

    logic                  accept_d;
    logic                  room_d;
    logic [31:0]           word_d;

    // in_ready_q is only ever set while in RECV, so it doubles as the state qualifier
    assign accept_d = in_if.in_valid & in_ready_q;
    // The top slot is reserved for the halt word
    assign room_d   = (wr_ptr_q != {ADDR_WIDTH{1'b1}});

    // Assembled word with the incoming byte merged into its lane
    always_comb begin
        word_d = word_q;
        case (byte_idx_q)
            2'd0:    word_d[7:0]   = in_if.in_byte;
            2'd1:    word_d[15:8]  = in_if.in_byte;
            2'd2:    word_d[23:16] = in_if.in_byte;
            2'd3:    word_d[31:24] = in_if.in_byte;
            default: word_d        = word_q;
        endcase
    end

    // Loader FSM with all outputs registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            word_q       <= 32'h0000_0000;
            byte_idx_q   <= 2'd0;
            wr_ptr_q     <= '0;
            last_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= 32'h0000_0000;
            core_run_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            word_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q      <= S_RECV;
                        word_q       <= 32'h0000_0000;
                        byte_idx_q   <= 2'd0;
                        wr_ptr_q     <= '0;
                        word_count_q <= '0;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                        core_run_q   <= 1'b0;
                        busy_q       <= 1'b1;
                        in_ready_q   <= 1'b1;
                    end
                end
                S_RECV: begin
                    if (accept_d) begin
                        word_q <= word_d;
                        if (byte_idx_q != 2'd3) begin
                            if (in_if.in_last) begin
                                // Program ended mid-word
                                state_q    <= S_ERROR;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                error_q    <= 1'b1;
                            end else begin
                                byte_idx_q <= byte_idx_q + 2'd1;
                            end
                        end else begin
                            byte_idx_q <= 2'd0;
                            if (!room_d) begin
                                // Word would consume the halt slot
                                state_q    <= S_ERROR;
                                in_ready_q <= 1'b0;
                                busy_q     <= 1'b0;
                                error_q    <= 1'b1;
                            end else begin
                                state_q      <= S_WRITE;
                                last_q       <= in_if.in_last;
                                in_ready_q   <= 1'b0;
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= wr_ptr_q;
                                imem_wdata_q <= word_d;
                            end
                        end
                    end
                end
                S_WRITE: begin
                    wr_ptr_q     <= wr_ptr_q + ADDR_WIDTH'(1);
                    word_count_q <= word_count_q + ADDR_WIDTH'(1);
                    if (last_q) begin
                        // Halt word goes to the slot right after the last program word
                        state_q      <= S_HALT_WR;
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= wr_ptr_q + ADDR_WIDTH'(1);
                        imem_wdata_q <= 32'h0000_0000;
                    end else begin
                        state_q    <= S_RECV;
                        imem_we_q  <= 1'b0;
                        in_ready_q <= 1'b1;
                    end
                end
                S_HALT_WR: begin
                    state_q    <= S_DONE;
                    imem_we_q  <= 1'b0;
                    done_q     <= 1'b1;
                    core_run_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                    imem_we_q  <= 1'b0;
                    core_run_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_if.in_ready = in_ready_q;
    assign imem_we        = imem_we_q;
    assign imem_addr      = imem_addr_q;
    assign imem_wdata     = imem_wdata_q;
    assign core_run       = core_run_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign word_count     = word_count_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader with a 4-word memory so the
// overflow boundary is reachable with short streams.
module tb_imem_program_loader;

    localparam int AW   = 2;
    localparam int MAXW = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_run;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] word_count;

    imem_program_loader_if s_if ();

    imem_program_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_if      (s_if),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_run   (core_run),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    int we_cnt       = 0;

    logic [AW+31:0] exp_q[$];
    logic [7:0]     prog[0:31];
    int             nbytes;
    int             last_pos;
    logic           exp_done;
    logic           exp_err;
    int             exp_wc;
    int             exp_we;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n === 1'b1 && imem_we === 1'b1) begin
            logic [AW+31:0] e;
            we_cnt++;
            check_eq("we_in_ready_low", 64'(s_if.in_ready), 64'd0);
            check_eq("sb_pending", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_eq("write_addr_data", 64'({imem_addr, imem_wdata}), 64'(e));
            end
        end
    end

    // Reference model: pushes expected writes and final outcome for prog[0:nbytes-1]
    task automatic model_push();
        logic [31:0] w;
        int wp;
        int i;
        w = 32'h0; wp = 0; exp_done = 1'b0; exp_err = 1'b0; exp_we = 0;
        for (i = 0; i < nbytes; i++) begin
            w[8*(i%4) +: 8] = prog[i];
            if (i % 4 != 3) begin
                if (i == last_pos) begin exp_err = 1'b1; break; end
            end else begin
                if (wp == MAXW - 1) begin exp_err = 1'b1; break; end
                exp_q.push_back({AW'(wp), w});
                exp_we++;
                wp++;
                if (i == last_pos) begin
                    exp_q.push_back({AW'(wp), 32'h0});
                    exp_we++;
                    exp_done = 1'b1;
                    break;
                end
            end
        end
        exp_wc = wp;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Drive n bytes, leaving in_valid low for gap cycles after each acceptance
    task automatic drive_stream(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            logic acc;
            acc = 1'b0;
            s_if.in_valid = 1'b1;
            s_if.in_byte  = prog[i];
            s_if.in_last  = (i == last_pos);
            for (int c = 0; c < 50 && !acc; c++) begin
                @(negedge clk);
                if (s_if.in_ready) begin
                    @(posedge clk); #1;
                    acc = 1'b1;
                end
            end
            s_if.in_valid = 1'b0;
            s_if.in_last  = 1'b0;
            check_eq("byte_accepted", 64'(acc), 64'd1);
            if (!acc) break;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic run_load(input string tag, input int gap);
        logic fin;
        fin = 1'b0;
        we_cnt = 0;
        model_push();
        pulse_start();
        drive_stream(nbytes, gap);
        for (int c = 0; c < 30 && !fin; c++) begin
            @(negedge clk);
            fin = done | error;
        end
        check_eq({tag, "_finished"}, 64'(fin), 64'd1);
        @(negedge clk);
        check_eq({tag, "_done"},       64'(done),        64'(exp_done));
        check_eq({tag, "_error"},      64'(error),       64'(exp_err));
        check_eq({tag, "_core_run"},   64'(core_run),    64'(exp_done));
        check_eq({tag, "_busy"},       64'(busy),        64'd0);
        check_eq({tag, "_in_ready"},   64'(s_if.in_ready), 64'd0);
        check_eq({tag, "_word_count"}, 64'(word_count),  64'(exp_wc));
        check_eq({tag, "_we_pulses"},  64'(we_cnt),      64'(exp_we));
        check_eq({tag, "_sb_empty"},   64'(exp_q.size()), 64'd0);
    endtask

    task automatic load_two_word();
        logic [7:0] b[8];
        b = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h33, 8'h05, 8'hB5, 8'h00};
        for (int i = 0; i < 8; i++) prog[i] = b[i];
        nbytes = 8; last_pos = 7;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0;
        s_if.in_valid = 1'b0; s_if.in_byte = 8'h00; s_if.in_last = 1'b0;

        // Reset with active-looking inputs
        #2; s_if.in_valid = 1'b1; start = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_in_ready",   64'(s_if.in_ready), 64'd0);
        check_eq("rst_imem_we",    64'(imem_we),    64'd0);
        check_eq("rst_core_run",   64'(core_run),   64'd0);
        check_eq("rst_done",       64'(done),       64'd0);
        check_eq("rst_error",      64'(error),      64'd0);
        check_eq("rst_busy",       64'(busy),       64'd0);
        check_eq("rst_word_count", 64'(word_count), 64'd0);
        s_if.in_valid = 1'b0; start = 1'b0;
        #2; rst_n = 1'b1; #1;
        check_eq("rst_release_quiet", 64'({s_if.in_ready, imem_we, core_run, busy, done, error}), 64'd0);
        @(posedge clk); #1;

        // Two-word program, back-to-back then stalled source
        load_two_word();
        run_load("two_word", 0);
        load_two_word();
        run_load("stalled", 3);

        // Partial final word, then a clean restart from addr0
        for (int i = 0; i < 6; i++) prog[i] = 8'(8'hA0 + i);
        nbytes = 6; last_pos = 5;
        run_load("partial", 0);
        load_two_word();
        run_load("after_err", 1);

        // Overflow: four full words, no last
        for (int i = 0; i < 16; i++) prog[i] = 8'($urandom_range(0, 255));
        nbytes = 16; last_pos = -1;
        run_load("overflow", 0);
        // Exactly fills memory: three words plus halt
        nbytes = 12; last_pos = 11;
        run_load("full", 0);

        // Reset after five accepted bytes
        we_cnt = 0;
        for (int i = 0; i < 8; i++) prog[i] = 8'($urandom_range(0, 255));
        nbytes = 5; last_pos = -1;
        model_push();
        pulse_start();
        drive_stream(5, 0);
        @(negedge clk); #2;
        rst_n = 1'b0; #1;
        check_eq("midrst_in_ready",   64'(s_if.in_ready), 64'd0);
        check_eq("midrst_busy",       64'(busy),       64'd0);
        check_eq("midrst_imem_we",    64'(imem_we),    64'd0);
        check_eq("midrst_word_count", 64'(word_count), 64'd0);
        check_eq("midrst_sb_empty",   64'(exp_q.size()), 64'd0);
        check_eq("midrst_we_pulses",  64'(we_cnt),     64'd1);
        @(posedge clk); #3; rst_n = 1'b1;
        @(posedge clk); #1;
        nbytes = 4; last_pos = 3;
        run_load("one_word", 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
